hwag_cfg_loader: RTL



---
 rtl/hwag_cfg_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hwag_cfg_loader.sv
// Configuration sequencer for the hwag angle generator: streams a table ROM image into
// the hwag SSRAM register port, then optionally reads it back and checks it under a mask.
module hwag_cfg_loader #(
    parameter int unsigned N_REGS = 68,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic [DATA_W-1:0] tbl_mask,
    output logic              ssram_we,
    output logic              ssram_re,
    output logic [ADDR_W-1:0] ssram_addr,
    output logic [DATA_W-1:0] ssram_wdata,
    output logic              ssram_oe,
    input  logic [DATA_W-1:0] ssram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        err_cnt,
    output logic              aborted
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREFETCH, S_WRITE, S_TURN, S_READ, S_CHECK_LAST, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO  = ADDR_W'(2);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic                verify;
    logic [DATA_W-1:0]   pipe_data;
    logic [DATA_W-1:0]   pipe_mask;
    logic [ADDR_W-1:0]   pipe_addr;
    logic                pipe_valid;
    logic                miss_c;

    // Read data lands one cycle after the strobe; compare it with the table word held from that read.
    assign miss_c = pipe_valid && (|((ssram_rdata ^ pipe_data) & pipe_mask));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            verify      <= 1'b0;
            pipe_data   <= '0;
            pipe_mask   <= '0;
            pipe_addr   <= '0;
            pipe_valid  <= 1'b0;
            tbl_addr    <= '0;
            ssram_we    <= 1'b0;
            ssram_re    <= 1'b0;
            ssram_addr  <= '0;
            ssram_wdata <= '0;
            ssram_oe    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_addr    <= '0;
            err_cnt     <= '0;
            aborted     <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            // Drop the bus at once; partial error status stays visible, pending compare is lost.
            state      <= S_IDLE;
            ssram_we   <= 1'b0;
            ssram_re   <= 1'b0;
            ssram_oe   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pipe_valid <= 1'b0;
            aborted    <= 1'b1;
        end else begin
            if (pipe_valid) begin
                pipe_valid <= 1'b0;
                if (miss_c) begin
                    err <= 1'b1;
                    if (err_cnt != 8'd255) err_cnt <= err_cnt + 8'd1;
                    if (!err) err_addr <= pipe_addr;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state    <= S_PREFETCH;
                        verify   <= verify_en;
                        err      <= 1'b0;
                        err_cnt  <= '0;
                        err_addr <= '0;
                        aborted  <= 1'b0;
                        tbl_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_PREFETCH: begin
                    state       <= S_WRITE;
                    idx         <= '0;
                    ssram_addr  <= '0;
                    ssram_wdata <= tbl_data;
                    ssram_we    <= 1'b1;
                    ssram_oe    <= 1'b1;
                    tbl_addr    <= ONE;
                end
                S_WRITE: begin
                    // Table address runs one ahead so a word is written every cycle.
                    if (idx == LAST) begin
                        state    <= S_TURN;
                        ssram_we <= 1'b0;
                        ssram_oe <= 1'b0;
                        tbl_addr <= '0;
                    end else begin
                        idx         <= idx + ONE;
                        ssram_addr  <= idx + ONE;
                        ssram_wdata <= tbl_data;
                        tbl_addr    <= idx + TWO;
                    end
                end
                S_TURN: begin
                    if (verify) begin
                        state      <= S_READ;
                        idx        <= '0;
                        ssram_addr <= '0;
                        tbl_addr   <= '0;
                        ssram_re   <= 1'b1;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_READ: begin
                    pipe_data  <= tbl_data;
                    pipe_mask  <= tbl_mask;
                    pipe_addr  <= idx;
                    pipe_valid <= 1'b1;
                    if (idx == LAST) begin
                        state    <= S_CHECK_LAST;
                        ssram_re <= 1'b0;
                    end else begin
                        idx        <= idx + ONE;
                        ssram_addr <= idx + ONE;
                        tbl_addr   <= idx + ONE;
                    end
                end
                S_CHECK_LAST: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
